// File: rtl/fft_butterfly_stage.sv
// Four-stage pipelined radix-2 DIT butterfly: A = a + w*b, B = a - w*b, Q2.10 twiddles.
// Optional macro FFT_BFLY_SCALE_EN halves every result (round half-up) before saturation.
module fft_butterfly_stage #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        inverse,
  input  logic                        tw_valid,
  input  logic [(N/2)*2*TW-1:0]       tw_bus,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [$clog2(N/2)-1:0]      tw_idx,
  input  logic [2*DW-1:0]             a_in,
  input  logic [2*DW-1:0]             b_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*DW-1:0]             a_out,
  output logic [2*DW-1:0]             b_out,
  output logic                        stage_done,
  output logic                        ovf
);

  localparam int unsigned IW = $clog2(N/2);
  localparam int unsigned PW = DW + TW;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned RW = DW + 2;
  localparam int unsigned AW = DW + 3;
  localparam int unsigned FB = TW - 2;

  localparam logic signed [TW-1:0] TwMin = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] TwMax = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [SW-1:0] RndK  = SW'(2 ** (FB - 1));
  localparam logic signed [AW-1:0] SatHi = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SatLo = ~SatHi;
  localparam logic [IW-1:0]        CntLast = IW'(N / 2 - 1);

  logic adv;
  logic accept;
  logic hs;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && tw_valid && !clear;
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;

  // Twiddle selection and conjugation
  logic [2*TW-1:0]       tw_word;
  logic signed [TW-1:0]  w_re;
  logic signed [TW-1:0]  w_im;
  logic signed [TW-1:0]  w_im_eff;

  always_comb begin
    tw_word = '0;
    for (int i = 0; i < int'(N / 2); i++) begin
      if (tw_idx == IW'(i)) begin
        tw_word = tw_bus[i*2*TW +: 2*TW];
      end
    end
  end

  assign w_re = tw_word[2*TW-1:TW];
  assign w_im = tw_word[TW-1:0];

  // -(-2.0) is not representable, so it clamps to the largest positive twiddle.
  always_comb begin
    w_im_eff = w_im;
    if (inverse) begin
      w_im_eff = (w_im == TwMin) ? TwMax : -w_im;
    end
  end

  // P1: operand and twiddle registers
  logic                  v1;
  logic signed [DW-1:0]  p1_ar, p1_ai, p1_br, p1_bi;
  logic signed [TW-1:0]  p1_wr, p1_wi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      p1_ar <= '0;
      p1_ai <= '0;
      p1_br <= '0;
      p1_bi <= '0;
      p1_wr <= '0;
      p1_wi <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1    <= accept;
      p1_ar <= a_in[2*DW-1:DW];
      p1_ai <= a_in[DW-1:0];
      p1_br <= b_in[2*DW-1:DW];
      p1_bi <= b_in[DW-1:0];
      p1_wr <= w_re;
      p1_wi <= w_im_eff;
    end
  end

  // P2: partial products
  logic                  v2;
  logic signed [DW-1:0]  p2_ar, p2_ai;
  logic signed [PW-1:0]  p2_rr, p2_ii, p2_ri, p2_ir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      p2_ar <= '0;
      p2_ai <= '0;
      p2_rr <= '0;
      p2_ii <= '0;
      p2_ri <= '0;
      p2_ir <= '0;
    end else if (clear) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2    <= v1;
      p2_ar <= p1_ar;
      p2_ai <= p1_ai;
      p2_rr <= PW'(p1_br) * PW'(p1_wr);
      p2_ii <= PW'(p1_bi) * PW'(p1_wi);
      p2_ri <= PW'(p1_br) * PW'(p1_wi);
      p2_ir <= PW'(p1_bi) * PW'(p1_wr);
    end
  end

  // P3: complex product, rounded back to sample scale
  logic signed [SW-1:0]  pr_full, pi_full;
  logic signed [RW-1:0]  pr_rnd, pi_rnd;

  assign pr_full = SW'(p2_rr) - SW'(p2_ii);
  assign pi_full = SW'(p2_ri) + SW'(p2_ir);
  assign pr_rnd  = RW'((pr_full + RndK) >>> FB);
  assign pi_rnd  = RW'((pi_full + RndK) >>> FB);

  logic                  v3;
  logic signed [DW-1:0]  p3_ar, p3_ai;
  logic signed [RW-1:0]  p3_pr, p3_pi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3    <= 1'b0;
      p3_ar <= '0;
      p3_ai <= '0;
      p3_pr <= '0;
      p3_pi <= '0;
    end else if (clear) begin
      v3 <= 1'b0;
    end else if (adv) begin
      v3    <= v2;
      p3_ar <= p2_ar;
      p3_ai <= p2_ai;
      p3_pr <= pr_rnd;
      p3_pi <= pi_rnd;
    end
  end

  // P4: add/subtract, optional halving, saturation
  function automatic logic [DW:0] sat_fn(input logic signed [AW-1:0] x);
    if (x > SatHi) begin
      return {1'b1, SatHi[DW-1:0]};
    end else if (x < SatLo) begin
      return {1'b1, SatLo[DW-1:0]};
    end else begin
      return {1'b0, x[DW-1:0]};
    end
  endfunction

  logic signed [AW-1:0] r_ar, r_ai, r_br, r_bi;
  logic [DW:0]          s_ar, s_ai, s_br, s_bi;
  logic                 any_sat;

  always_comb begin
    r_ar = AW'(p3_ar) + AW'(p3_pr);
    r_ai = AW'(p3_ai) + AW'(p3_pi);
    r_br = AW'(p3_ar) - AW'(p3_pr);
    r_bi = AW'(p3_ai) - AW'(p3_pi);
`ifdef FFT_BFLY_SCALE_EN
    r_ar = (r_ar + AW'(1)) >>> 1;
    r_ai = (r_ai + AW'(1)) >>> 1;
    r_br = (r_br + AW'(1)) >>> 1;
    r_bi = (r_bi + AW'(1)) >>> 1;
`endif
    s_ar    = sat_fn(r_ar);
    s_ai    = sat_fn(r_ai);
    s_br    = sat_fn(r_br);
    s_bi    = sat_fn(r_bi);
    any_sat = s_ar[DW] || s_ai[DW] || s_br[DW] || s_bi[DW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= v3;
      if (v3) begin
        a_out <= {s_ar[DW-1:0], s_ai[DW-1:0]};
        b_out <= {s_br[DW-1:0], s_bi[DW-1:0]};
        ovf   <= ovf || any_sat;
      end
    end
  end

  // Output handshake counter; a handshake coinciding with clear is dropped.
  logic [IW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      stage_done <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      stage_done <= 1'b0;
    end else begin
      stage_done <= hs && (cnt == CntLast);
      if (hs) begin
        cnt <= (cnt == CntLast) ? '0 : cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Randomized and directed bench for fft_butterfly_stage against an arithmetic reference model.
module tb_fft_butterfly_stage;

  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         inverse;
  logic         tw_valid;
  logic [191:0] tw_bus;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   tw_idx;
  logic [31:0]  a_in;
  logic [31:0]  b_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic         stage_done;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  fft_butterfly_stage #(.N(16), .DW(16), .TW(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .inverse    (inverse),
    .tw_valid   (tw_valid),
    .tw_bus     (tw_bus),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tw_idx     (tw_idx),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .b_out      (b_out),
    .stage_done (stage_done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference butterfly from the arithmetic rules, using plain integers.
  function automatic int clamp16(input int x, inout bit s);
    if (x > 32767) begin
      s = 1'b1;
      return 32767;
    end
    if (x < -32768) begin
      s = 1'b1;
      return -32768;
    end
    return x;
  endfunction

  function automatic int keep18(input int x);
    logic [17:0] t;
    t = x[17:0];
    return int'($signed(t));
  endfunction

  task automatic ref_bfly(input logic [31:0] a, input logic [31:0] b, input logic [23:0] w,
                          input bit inv, output logic [31:0] ao, output logic [31:0] bo,
                          output bit sat);
    int ar, ai, br, bi, wr, wi, pr, pi;
    int v[4];
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    wr = int'($signed(w[23:12]));
    wi = int'($signed(w[11:0]));
    if (inv) wi = (wi == -2048) ? 2047 : -wi;
    pr = keep18((br * wr - bi * wi + 512) >>> 10);
    pi = keep18((br * wi + bi * wr + 512) >>> 10);
    v[0] = ar + pr;
    v[1] = ai + pi;
    v[2] = ar - pr;
    v[3] = ai - pi;
    sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef FFT_BFLY_SCALE_EN
      v[k] = (v[k] + 1) >>> 1;
`endif
      v[k] = clamp16(v[k], sat);
    end
    ao = {16'(v[0]), 16'(v[1])};
    bo = {16'(v[2]), 16'(v[3])};
  endtask

  // Transaction-level model: four result slots between acceptance and the output.
  bit          sv[4];
  logic [31:0] sa[4];
  logic [31:0] sb[4];
  bit          ss[4];
  int          mcnt;
  bit          msd;
  bit          movf;

  always @(negedge clk) begin : monitor
    bit er;
    bit hsm;
    if (rst) begin
      for (int i = 0; i < 4; i++) sv[i] = 1'b0;
      mcnt = 0;
      msd  = 1'b0;
      movf = 1'b0;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_data", {a_out, b_out}, 64'd0);
      check("rst_stage_done", 64'(stage_done), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
    end else begin
      check("out_valid", 64'(out_valid), 64'(sv[3]));
      if (sv[3]) begin
        check("a_out", 64'(a_out), 64'(sa[3]));
        check("b_out", 64'(b_out), 64'(sb[3]));
      end
      check("stage_done", 64'(stage_done), 64'(msd));
      check("ovf", 64'(ovf), 64'(movf));
      er = (!sv[3] || out_ready) && tw_valid && !clear;
      check("in_ready", 64'(in_ready), 64'(er));
      if (clear) begin
        for (int i = 0; i < 4; i++) sv[i] = 1'b0;
        mcnt = 0;
        msd  = 1'b0;
        movf = 1'b0;
      end else if (!sv[3] || out_ready) begin
        hsm = sv[3] && out_ready;
        msd = hsm && (mcnt == HALF - 1);
        if (hsm) mcnt = (mcnt + 1) % HALF;
        if (sv[2] && ss[2]) movf = 1'b1;
        for (int i = 3; i > 0; i--) begin
          sv[i] = sv[i-1];
          sa[i] = sa[i-1];
          sb[i] = sb[i-1];
          ss[i] = ss[i-1];
        end
        sv[0] = in_valid && er;
        ref_bfly(a_in, b_in, tw_bus[tw_idx*24 +: 24], inverse, sa[0], sb[0], ss[0]);
      end else begin
        msd = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Single pair; returns cycles until out_valid (10 = timed out) and the outputs.
  task automatic one_pair(input logic [31:0] a, input logic [31:0] b, input logic [2:0] idx,
                          input bit inv, output int lat, output logic [31:0] ao,
                          output logic [31:0] bo);
    a_in = a;
    b_in = b;
    tw_idx = idx;
    inverse = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    ao = a_out;
    bo = b_out;
    tick();
  endtask

  // Eight random pairs back to back, out_ready low for cycles [s0, s1].
  task automatic stream8(input int s0, input int s1, input string tag);
    int k = 0, c = 0, nout = 0, sd_hits = 0, sd_at = -1;
    bit acc;
    logic [31:0] pa[HALF];
    logic [31:0] pb[HALF];
    for (int i = 0; i < HALF; i++) begin
      pa[i] = $urandom;
      pb[i] = {16'($urandom_range(4000)) - 16'd2000, 16'($urandom_range(4000)) - 16'd2000};
    end
    while (nout < HALF && c < 200) begin
      out_ready = !(c >= s0 && c <= s1);
      in_valid  = (k < HALF);
      if (k < HALF) begin
        a_in   = pa[k];
        b_in   = pb[k];
        tw_idx = 3'(k);
      end
      @(negedge clk);
      if (stage_done) begin
        sd_hits++;
        sd_at = nout;
      end
      if (s0 >= 0 && c == s0 + 1) check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) nout++;
      tick();
      if (acc) k++;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    if (stage_done) begin
      sd_hits++;
      sd_at = nout;
    end
    tick();
    check({tag, "_outputs"}, 64'(nout), 64'(HALF));
    check({tag, "_done_pulses"}, 64'(sd_hits), 64'd1);
    check({tag, "_done_position"}, 64'(sd_at), 64'(HALF));
  endtask

  initial begin
    int lat;
    logic [31:0] ao, bo;
    rst = 1'b1;
    clear = 1'b0;
    inverse = 1'b0;
    tw_valid = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tw_idx = '0;
    a_in = '0;
    b_in = '0;
    tw_bus = '0;
    tw_bus[0*24 +: 24] = {12'h400, 12'h000};
    tw_bus[1*24 +: 24] = {12'h000, 12'hC00};
    for (int i = 2; i < HALF; i++) tw_bus[i*24 +: 24] = 24'($urandom);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // w = 1.0, a = 100, b = 50
    one_pair({16'd100, 16'd0}, {16'd50, 16'd0}, 3'd0, 1'b0, lat, ao, bo);
    check("unity_latency", 64'(lat), 64'd4);
`ifdef FFT_BFLY_SCALE_EN
    check("unity_a", 64'(ao), {32'd0, 16'd75, 16'd0});
    check("unity_b", 64'(bo), {32'd0, 16'd25, 16'd0});
`else
    check("unity_a", 64'(ao), {32'd0, 16'd150, 16'd0});
    check("unity_b", 64'(bo), {32'd0, 16'd50, 16'd0});
`endif
    check("unity_ovf", 64'(ovf), 64'd0);

    // w = -j, forward and inverse
    one_pair({16'd10, 16'd0}, {16'd0, 16'd100}, 3'd1, 1'b0, lat, ao, bo);
`ifdef FFT_BFLY_SCALE_EN
    check("negj_fwd_a", 64'(ao), {32'd0, 16'd55, 16'd0});
    check("negj_fwd_b", 64'(bo), {32'd0, -16'sd45, 16'd0});
`else
    check("negj_fwd_a", 64'(ao), {32'd0, 16'd110, 16'd0});
    check("negj_fwd_b", 64'(bo), {32'd0, -16'sd90, 16'd0});
`endif
    one_pair({16'd10, 16'd0}, {16'd0, 16'd100}, 3'd1, 1'b1, lat, ao, bo);
`ifdef FFT_BFLY_SCALE_EN
    check("negj_inv_a", 64'(ao), {32'd0, -16'sd45, 16'd0});
    check("negj_inv_b", 64'(bo), {32'd0, 16'd55, 16'd0});
`else
    check("negj_inv_a", 64'(ao), {32'd0, -16'sd90, 16'd0});
    check("negj_inv_b", 64'(bo), {32'd0, 16'd110, 16'd0});
`endif

    // Growth beyond full scale
    one_pair({16'd32000, 16'd0}, {16'd1000, 16'd0}, 3'd0, 1'b0, lat, ao, bo);
`ifdef FFT_BFLY_SCALE_EN
    check("sat_a", 64'(ao[31:16]), 64'd16500);
    check("sat_b", 64'(bo[31:16]), 64'd15500);
    check("sat_ovf", 64'(ovf), 64'd0);
`else
    check("sat_a", 64'(ao[31:16]), 64'd32767);
    check("sat_b", 64'(bo[31:16]), 64'd31000);
    check("sat_ovf", 64'(ovf), 64'd1);
    repeat (3) tick();
    check("sat_ovf_sticky", 64'(ovf), 64'd1);
`endif
    pulse_clear();
    check("clear_ovf", 64'(ovf), 64'd0);

    // Back-to-back stream with a downstream stall
    stream8(5, 7, "stall");

    // Async reset with pairs in flight
    for (int i = 0; i < 6; i++) begin
      a_in = $urandom;
      b_in = $urandom;
      tw_idx = 3'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    stream8(-1, -1, "post_rst");

    // Twiddle bus not yet valid
    tw_valid = 1'b0;
    in_valid = 1'b1;
    a_in = {16'd7, 16'd3};
    b_in = {16'd2, 16'd1};
    tw_idx = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("twv_low_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    check("twv_low_no_output", 64'(out_valid), 64'd0);
    tw_valid = 1'b1;
    @(negedge clk);
    check("twv_high_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("twv_accepted_output", 64'(out_valid), 64'd1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      tw_valid  = ($urandom % 8) != 0;
      clear     = ($urandom % 64) == 0;
      inverse   = $urandom;
      tw_idx    = 3'($urandom);
      if ($urandom % 2) begin
        a_in = $urandom;
        b_in = $urandom;
      end else begin
        a_in = {16'($urandom_range(4000)) - 16'd2000, 16'($urandom_range(4000)) - 16'd2000};
        b_in = {16'($urandom_range(4000)) - 16'd2000, 16'($urandom_range(4000)) - 16'd2000};
      end
      if (($urandom % 32) == 0) tw_bus[($urandom % HALF)*24 +: 24] = 24'($urandom);
      if (($urandom % 50) == 0) tw_bus[($urandom % HALF)*24 +: 24] = {12'h800, 12'h800};
      tick();
    end
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
